// File: rtl/irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irq_ctrl_pkg
//   Shared definitions for the 68000 interrupt controller:
//     - register word addresses of the CPU-mapped register file
//     - the CPU function code that marks an interrupt-acknowledge cycle
//     - acknowledge state machine encoding
//     - the 68000 spurious-interrupt vector number
//     - byte_mask(): expands the {upper,lower} byte strobes to a 16-bit mask
//   Optional build macro used by the controller: IRQ_CTRL_VECTOR_EN.
// -----------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam logic [2:0] REG_PEND     = 3'd0;
  localparam logic [2:0] REG_ENABLE   = 3'd1;
  localparam logic [2:0] REG_MODE     = 3'd2;
  localparam logic [2:0] REG_POLARITY = 3'd3;
  localparam logic [2:0] REG_PRIO0    = 3'd4;
  localparam logic [2:0] REG_PRIO1    = 3'd5;
  localparam logic [2:0] REG_PRIO2    = 3'd6;
  localparam logic [2:0] REG_PRIO3    = 3'd7;

  localparam logic [2:0] FC_IACK      = 3'b111;
  localparam logic [7:0] SPURIOUS_VEC = 8'd24;

  typedef enum logic [0:0] {
    ACK_IDLE = 1'b0,
    ACK_BUSY = 1'b1
  } ack_state_t;

  function automatic logic [15:0] byte_mask(input logic [1:0] strobes);
    return {{8{strobes[1]}}, {8{strobes[0]}}};
  endfunction

endpackage

// File: rtl/irq_prio_encoder.sv
// -----------------------------------------------------------------------------
// irq_prio_encoder
//   Combinational arbitration over the effective (pending & enabled) sources.
//   Ports:
//     eff_i        in  NUM_SRC    pending & enabled sources
//     prio_i       in  3*NUM_SRC  packed priorities, source n at [3n +: 3]
//     match_lvl_i  in  3          level being acknowledged by the CPU
//     level_o      out 3          highest priority among effective sources (0 = none)
//     match_idx_o  out 4          lowest-index effective source whose priority equals match_lvl_i
//     match_hit_o  out 1          a source matched match_lvl_i
//   Priority 0 means "never fires", so such sources can neither raise the
//   level nor be selected by an acknowledge.
// -----------------------------------------------------------------------------
module irq_prio_encoder
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]   eff_i,
  input  logic [3*NUM_SRC-1:0] prio_i,
  input  logic [2:0]           match_lvl_i,
  output logic [2:0]           level_o,
  output logic [3:0]           match_idx_o,
  output logic                 match_hit_o
);

  always_comb begin
    level_o     = 3'd0;
    match_idx_o = 4'd0;
    match_hit_o = 1'b0;
    // Scan from the top index down so the lowest matching index is written last.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eff_i[i]) begin
        if (prio_i[3*i +: 3] > level_o) begin
          level_o = prio_i[3*i +: 3];
        end
        if ((prio_i[3*i +: 3] == match_lvl_i) && (prio_i[3*i +: 3] != 3'd0)) begin
          match_idx_o = 4'(i);
          match_hit_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/m68k_irq_ctrl.sv
// -----------------------------------------------------------------------------
// m68k_irq_ctrl
//   68000 interrupt controller: NUM_SRC sources with per-source enable,
//   edge/level mode, polarity and 3-bit priority. Drives the fx68k IPL pins
//   and clears the winning edge-latched source on the interrupt-acknowledge
//   cycle.
//   Parameters: NUM_SRC (1..16), SYNC_STAGES (0..3), VECTOR_BASE (vector build only)
//   Build macro IRQ_CTRL_VECTOR_EN: replaces iack_autovec with a vectored
//   acknowledge (iack_vec_dtack, iack_vector).
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     src               raw interrupt sources
//     sel, wr, address  register window select, {upper,lower} byte strobes, word address
//     din / dout        write data / combinational read data
//     cpu_fc, cpu_as_n  CPU function code and address strobe
//     iack_lvl          CPU A3:A1 during IACK
//     ipl_n             registered IPL2n..IPL0n
//     iack_autovec      high for the whole IACK cycle (autovector build)
//     iack_vec_dtack    high for the whole IACK cycle (vector build)
//     iack_vector       vector number for the IACK cycle (vector build)
//   Register map: 0 PEND (R/W1C), 1 ENABLE, 2 MODE (1=edge), 3 POLARITY
//   (1=invert), 4..7 PRIO, four 4-bit nibbles per word, bits [2:0] used.
// -----------------------------------------------------------------------------
module m68k_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
`ifdef IRQ_CTRL_VECTOR_EN
  parameter int VECTOR_BASE = 64,
`endif
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               sel,
  input  logic [1:0]         wr,
  input  logic [2:0]         address,
  input  logic [15:0]        din,
  output logic [15:0]        dout,
  input  logic [2:0]         cpu_fc,
  input  logic               cpu_as_n,
  input  logic [2:0]         iack_lvl,
  output logic [2:0]         ipl_n,
`ifdef IRQ_CTRL_VECTOR_EN
  output logic               iack_vec_dtack,
  output logic [7:0]         iack_vector
`else
  output logic               iack_autovec
`endif
);

  // Register bits at or above NUM_SRC do not exist: they read 0 and ignore writes.
  localparam logic [15:0] VALID = 16'((32'd1 << NUM_SRC) - 32'd1);

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] src_sync;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign src_sync = src;
  end else begin : g_sync
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= src;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign src_sync = sync_q[SYNC_STAGES-1];
  end

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [15:0]        pend_q, pend_d;
  logic [15:0]        enable_q, enable_d;
  logic [15:0]        mode_q, mode_d;
  logic [15:0]        pol_q, pol_d;
  logic [NUM_SRC-1:0] s_prev_q;
  logic [2:0]         ipl_n_q;
  ack_state_t         state_q, state_d;
  logic [3*16-1:0]    prio_flat;

  logic [1:0]         wr_en;
  logic [15:0]        wmask;
  logic [NUM_SRC-1:0] s;
  logic [15:0]        s16;
  logic [15:0]        edge_set;
  logic [15:0]        w1c;
  logic [15:0]        ack_clr;

  assign wr_en    = sel ? wr : 2'b00;
  assign wmask    = byte_mask(wr_en) & VALID;
  assign s        = src_sync ^ pol_q[NUM_SRC-1:0];
  assign s16      = 16'(s);
  assign edge_set = 16'(s & ~s_prev_q);
  assign w1c      = (address == REG_PEND) ? (din & wmask) : 16'd0;

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    pol_d    = pol_q;
    case (address)
      REG_ENABLE:   enable_d = (enable_q & ~wmask) | (din & wmask);
      REG_MODE:     mode_d   = (mode_q   & ~wmask) | (din & wmask);
      REG_POLARITY: pol_d    = (pol_q    & ~wmask) | (din & wmask);
      default:      ;
    endcase
  end

  // Priority nibbles: one small register per existing source.
  for (genvar gi = 0; gi < 16; gi++) begin : g_prio
    if (gi < NUM_SRC) begin : g_used
      logic [2:0] prio_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          prio_q <= 3'd0;
        end else if ((address == 3'(REG_PRIO0 + gi / 4)) && wr_en[(gi % 4) / 2]) begin
          prio_q <= din[4*(gi % 4) +: 3];
        end
      end
      assign prio_flat[3*gi +: 3] = prio_q;
    end else begin : g_absent
      assign prio_flat[3*gi +: 3] = 3'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [2:0] level;
  logic [3:0] match_idx;
  logic       match_hit;

  irq_prio_encoder #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .eff_i       (pend_q[NUM_SRC-1:0] & enable_q[NUM_SRC-1:0]),
    .prio_i      (prio_flat[3*NUM_SRC-1:0]),
    .match_lvl_i (iack_lvl),
    .level_o     (level),
    .match_idx_o (match_idx),
    .match_hit_o (match_hit)
  );

  // ---------------------------------------------------------------------------
  // Acknowledge state machine
  // ---------------------------------------------------------------------------
  logic entry;
  logic in_ack;

  // Gated by reset so the acknowledge outputs stay low while reset is held.
  assign entry  = ~reset && (state_q == ACK_IDLE) && (cpu_fc == FC_IACK) && ~cpu_as_n;
  // Drops combinationally with cpu_as_n so the cycle ends exactly with the strobe.
  assign in_ack = entry || ((state_q == ACK_BUSY) && ~cpu_as_n);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACK_IDLE: if (entry)    state_d = ACK_BUSY;
      ACK_BUSY: if (cpu_as_n) state_d = ACK_IDLE;
      default:                state_d = ACK_IDLE;
    endcase
  end

  // Only edge-mode winners are cleared; level bits simply follow their input.
  assign ack_clr = (entry && match_hit && mode_q[match_idx]) ? (16'd1 << match_idx) : 16'd0;

  // Edge bits: a new edge beats a same-cycle W1C or acknowledge clear.
  always_comb begin
    pend_d = (mode_q & ((pend_q & ~w1c & ~ack_clr) | edge_set))
           | (~mode_q & s16);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= 16'd0;
      enable_q <= 16'd0;
      mode_q   <= VALID;
      pol_q    <= 16'd0;
      s_prev_q <= '0;
      ipl_n_q  <= 3'b111;
      state_q  <= ACK_IDLE;
    end else begin
      pend_q   <= pend_d & VALID;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      pol_q    <= pol_d;
      s_prev_q <= s;
      ipl_n_q  <= ~level;
      state_q  <= state_d;
    end
  end

  assign ipl_n = ipl_n_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [15:0] reg_rdata;

  always_comb begin
    reg_rdata = 16'd0;
    case (address)
      REG_PEND:     reg_rdata = pend_q;
      REG_ENABLE:   reg_rdata = enable_q;
      REG_MODE:     reg_rdata = mode_q;
      REG_POLARITY: reg_rdata = pol_q;
      REG_PRIO0, REG_PRIO1, REG_PRIO2, REG_PRIO3: begin
        for (int n = 0; n < 4; n++) begin
          reg_rdata[4*n +: 3] = prio_flat[3*(4*int'(address[1:0]) + n) +: 3];
        end
      end
      default: reg_rdata = 16'd0;
    endcase
  end

`ifdef IRQ_CTRL_VECTOR_EN
  // The acknowledged source is captured on entry so register writes during
  // the bus cycle cannot change the vector already being returned.
  logic [3:0] win_idx_q;
  logic       win_hit_q;
  logic [7:0] vec_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_idx_q <= 4'd0;
      win_hit_q <= 1'b0;
    end else if (entry) begin
      win_idx_q <= match_idx;
      win_hit_q <= match_hit;
    end
  end

  always_comb begin
    if (entry) begin
      vec_now = match_hit ? (8'(VECTOR_BASE) + {4'd0, match_idx}) : SPURIOUS_VEC;
    end else begin
      vec_now = win_hit_q ? (8'(VECTOR_BASE) + {4'd0, win_idx_q}) : SPURIOUS_VEC;
    end
  end

  assign iack_vector    = vec_now;
  assign iack_vec_dtack = in_ack;
  assign dout           = in_ack ? {8'h00, vec_now} : reg_rdata;
`else
  assign iack_autovec = in_ack;
  assign dout         = reg_rdata;
`endif

endmodule

// File: tb/tb_m68k_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_m68k_irq_ctrl
//   Self-checking bench for m68k_irq_ctrl (NUM_SRC=8, SYNC_STAGES=2).
//   Register-file behaviour is driven from a vector table; interrupt latency,
//   arbitration, acknowledge clearing and the simultaneous set/clear cases are
//   hand-written sequences. Every expected value goes through a scoreboard
//   queue and is popped when the matching DUT output is sampled.
//   Also builds with IRQ_CTRL_VECTOR_EN defined (vectored acknowledge).
// -----------------------------------------------------------------------------
module tb_m68k_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NUM_SRC     = 8;
  localparam int SYNC_STAGES = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] src;
  logic               sel;
  logic [1:0]         wr;
  logic [2:0]         address;
  logic [15:0]        din;
  logic [15:0]        dout;
  logic [2:0]         cpu_fc;
  logic               cpu_as_n;
  logic [2:0]         iack_lvl;
  logic [2:0]         ipl_n;
`ifdef IRQ_CTRL_VECTOR_EN
  logic               iack_vec_dtack;
  logic [7:0]         iack_vector;
  logic [7:0]         ack_vec_entry;
  logic [7:0]         ack_vec_busy;
  logic [15:0]        ack_dout_busy;
`else
  logic               iack_autovec;
`endif

  always #5 clk = ~clk;

  m68k_irq_ctrl #(
    .NUM_SRC     (NUM_SRC),
`ifdef IRQ_CTRL_VECTOR_EN
    .VECTOR_BASE (64),
`endif
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .src            (src),
    .sel            (sel),
    .wr             (wr),
    .address        (address),
    .din            (din),
    .dout           (dout),
    .cpu_fc         (cpu_fc),
    .cpu_as_n       (cpu_as_n),
    .iack_lvl       (iack_lvl),
    .ipl_n          (ipl_n),
`ifdef IRQ_CTRL_VECTOR_EN
    .iack_vec_dtack (iack_vec_dtack),
    .iack_vector    (iack_vector)
`else
    .iack_autovec   (iack_autovec)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string name, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] act);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h, nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: %h", e.name, act);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Bus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [1:0] w, input logic [15:0] d);
    sel = 1'b1; address = a; wr = w; din = d;
    tick();
    sel = 1'b0; wr = 2'b00; din = 16'h0000;
  endtask

  task automatic rd_check(input logic [2:0] a, input string name, input logic [15:0] exp);
    address = a;
    expect_val(name, exp);
    #1;
    check(dout);
  endtask

  task automatic ipl_check(input string name, input logic [2:0] exp);
    expect_val(name, {13'd0, exp});
    check({13'd0, ipl_n});
  endtask

  task automatic pulse_src(input logic [NUM_SRC-1:0] mask);
    src = src | mask;
    tick();
    src = src & ~mask;
  endtask

  // One IACK bus cycle: entry cycle, one cycle in ACK, then AS rises.
  task automatic iack(input logic [2:0] lvl);
    cpu_fc = 3'b111; iack_lvl = lvl; cpu_as_n = 1'b0;
    #1;
`ifdef IRQ_CTRL_VECTOR_EN
    expect_val("iack_dtack_entry", 16'd1);
    check({15'd0, iack_vec_dtack});
    ack_vec_entry = iack_vector;
`else
    expect_val("iack_autovec_entry", 16'd1);
    check({15'd0, iack_autovec});
`endif
    tick();
`ifdef IRQ_CTRL_VECTOR_EN
    expect_val("iack_dtack_busy", 16'd1);
    check({15'd0, iack_vec_dtack});
    ack_vec_busy  = iack_vector;
    ack_dout_busy = dout;
`else
    expect_val("iack_autovec_busy", 16'd1);
    check({15'd0, iack_autovec});
`endif
    cpu_as_n = 1'b1;
    #1;
`ifdef IRQ_CTRL_VECTOR_EN
    expect_val("iack_dtack_as_high", 16'd0);
    check({15'd0, iack_vec_dtack});
`else
    expect_val("iack_autovec_as_high", 16'd0);
    check({15'd0, iack_autovec});
`endif
    tick();
    cpu_fc = 3'b000; iack_lvl = 3'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Register-file vectors: write {addr, strobes, data}, then read back.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0]  addr;
    logic [1:0]  wr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'd1, 2'b11, 16'hFFFF, 16'h00FF}; // ENABLE: bits >= NUM_SRC ignored
    tbl[1]  = '{3'd1, 2'b10, 16'h0000, 16'h00FF}; // upper strobe leaves low byte
    tbl[2]  = '{3'd1, 2'b01, 16'h0000, 16'h0000};
    tbl[3]  = '{3'd2, 2'b01, 16'h00A5, 16'h00A5}; // MODE
    tbl[4]  = '{3'd2, 2'b11, 16'hFFFF, 16'h00FF};
    tbl[5]  = '{3'd3, 2'b11, 16'h1234, 16'h0034}; // POLARITY: inverted idle lines
    tbl[6]  = '{3'd3, 2'b11, 16'h0000, 16'h0000};
    tbl[7]  = '{3'd0, 2'b00, 16'h0000, 16'h0034}; // edges from the polarity flip
    tbl[8]  = '{3'd0, 2'b10, 16'hFFFF, 16'h0034}; // W1C upper byte: nothing there
    tbl[9]  = '{3'd0, 2'b01, 16'h0014, 16'h0020}; // W1C bits 2,4
    tbl[10] = '{3'd0, 2'b11, 16'hFFFF, 16'h0000};
    tbl[11] = '{3'd4, 2'b11, 16'hFFFF, 16'h7777}; // PRIO: nibble bit 3 unused
    tbl[12] = '{3'd4, 2'b10, 16'h0000, 16'h0077};
    tbl[13] = '{3'd5, 2'b01, 16'h0012, 16'h0012};
    tbl[14] = '{3'd6, 2'b11, 16'h1111, 16'h0000}; // sources 8..11 absent
    tbl[15] = '{3'd4, 2'b11, 16'h0000, 16'h0000};
    tbl[16] = '{3'd5, 2'b11, 16'h0000, 16'h0000};

    reset = 1'b1; src = '0; sel = 1'b0; wr = 2'b00; address = 3'd0; din = 16'h0000;
    cpu_fc = 3'b000; cpu_as_n = 1'b1; iack_lvl = 3'd0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    rd_check(3'd0, "rst_pend",  16'h0000);
    rd_check(3'd1, "rst_enable", 16'h0000);
    rd_check(3'd2, "rst_mode",  16'h00FF);
    rd_check(3'd3, "rst_pol",   16'h0000);
    rd_check(3'd4, "rst_prio0", 16'h0000);
    rd_check(3'd5, "rst_prio1", 16'h0000);
    ipl_check("rst_ipl", 3'b111);
`ifdef IRQ_CTRL_VECTOR_EN
    expect_val("rst_dtack", 16'd0);
    check({15'd0, iack_vec_dtack});
`else
    expect_val("rst_autovec", 16'd0);
    check({15'd0, iack_autovec});
`endif

    for (int i = 0; i < NVEC; i++) begin
      wr_reg(tbl[i].addr, tbl[i].wr, tbl[i].din);
      rd_check(tbl[i].addr, $sformatf("tbl%0d_addr%0d", i, tbl[i].addr), tbl[i].exp);
    end

    // Latency: src[0] edge reaches ipl_n exactly SYNC_STAGES+2 edges later.
    wr_reg(3'd1, 2'b11, 16'h0001);
    wr_reg(3'd4, 2'b11, 16'h0003);
    src[0] = 1'b1;
    tick();                                   // edge 1 samples the pulse
    src[0] = 1'b0;
    for (int k = 2; k <= SYNC_STAGES + 2; k++) begin
      tick();
      if (k == SYNC_STAGES + 1) ipl_check("lat_before", 3'b111);
      if (k == SYNC_STAGES + 2) ipl_check("lat_at", 3'b100);
    end
    rd_check(3'd0, "lat_pend", 16'h0001);
    wr_reg(3'd0, 2'b01, 16'h0001);
    tick();
    ipl_check("lat_w1c_ipl", 3'b111);
    wr_reg(3'd1, 2'b11, 16'h0000);
    wr_reg(3'd4, 2'b11, 16'h0000);

    // src0 prio 2 and src5 prio 5: highest level wins, ack clears only src5.
    wr_reg(3'd1, 2'b11, 16'h0021);
    wr_reg(3'd4, 2'b11, 16'h0002);
    wr_reg(3'd5, 2'b11, 16'h0050);
    pulse_src(8'h21);
    repeat (SYNC_STAGES + 2) tick();
    ipl_check("two_lvl_ipl", 3'b010);
    rd_check(3'd0, "two_lvl_pend", 16'h0021);
    iack(3'd5);
    rd_check(3'd0, "two_lvl_pend_after", 16'h0001);
    ipl_check("two_lvl_ipl_after", 3'b101);
    wr_reg(3'd0, 2'b11, 16'hFFFF);
    wr_reg(3'd4, 2'b11, 16'h0000);
    wr_reg(3'd5, 2'b11, 16'h0000);

    // src1, src2 both prio 4: lowest index is acknowledged first.
    wr_reg(3'd1, 2'b11, 16'h0006);
    wr_reg(3'd4, 2'b11, 16'h0440);
    pulse_src(8'h06);
    repeat (SYNC_STAGES + 2) tick();
    ipl_check("tie_ipl", 3'b011);
    iack(3'd4);
    rd_check(3'd0, "tie_pend_1st", 16'h0004);
    iack(3'd4);
    rd_check(3'd0, "tie_pend_2nd", 16'h0000);
    ipl_check("tie_ipl_after", 3'b111);
    wr_reg(3'd4, 2'b11, 16'h0000);

    // Level-mode src3: W1C and ack cannot clear it; it follows the input.
    wr_reg(3'd2, 2'b11, 16'h00F7);
    wr_reg(3'd1, 2'b11, 16'h0008);
    wr_reg(3'd4, 2'b11, 16'h1000);
    src[3] = 1'b1;
    repeat (SYNC_STAGES + 2) tick();
    rd_check(3'd0, "lvl_pend_held", 16'h0008);
    ipl_check("lvl_ipl_held", 3'b110);
    wr_reg(3'd0, 2'b11, 16'h0008);
    rd_check(3'd0, "lvl_pend_w1c", 16'h0008);
    iack(3'd1);
    rd_check(3'd0, "lvl_pend_ack", 16'h0008);
    src[3] = 1'b0;
    repeat (SYNC_STAGES + 2) tick();
    rd_check(3'd0, "lvl_pend_release", 16'h0000);
    ipl_check("lvl_ipl_release", 3'b111);
    wr_reg(3'd2, 2'b11, 16'h00FF);
    wr_reg(3'd4, 2'b11, 16'h0000);

    // Edge on src4 lands on the same edge as W1C of bit 4: set wins.
    wr_reg(3'd1, 2'b11, 16'h0010);
    wr_reg(3'd5, 2'b11, 16'h0003);
    src[4] = 1'b1;
    for (int i = 0; i < SYNC_STAGES; i++) begin
      tick();
      src[4] = 1'b0;
    end
    wr_reg(3'd0, 2'b11, 16'h0010);
    src[4] = 1'b0;
    rd_check(3'd0, "setwins_pend", 16'h0010);
    tick();
    ipl_check("setwins_ipl", 3'b100);
    iack(3'd6);                               // nothing at level 6: spurious
    rd_check(3'd0, "spurious_pend", 16'h0010);
`ifdef IRQ_CTRL_VECTOR_EN
    expect_val("spurious_vector", {8'h00, SPURIOUS_VEC});
    check({8'h00, ack_vec_busy});
`endif
    wr_reg(3'd0, 2'b11, 16'hFFFF);
    wr_reg(3'd5, 2'b11, 16'h0000);

`ifdef IRQ_CTRL_VECTOR_EN
    // Vectored acknowledge: src7 prio 1 -> vector 64 + 7.
    wr_reg(3'd1, 2'b11, 16'h0080);
    wr_reg(3'd5, 2'b11, 16'h1000);
    pulse_src(8'h80);
    repeat (SYNC_STAGES + 2) tick();
    ipl_check("vec_ipl", 3'b110);
    iack(3'd1);
    expect_val("vec_entry", 16'd71);
    check({8'h00, ack_vec_entry});
    expect_val("vec_busy", 16'd71);
    check({8'h00, ack_vec_busy});
    expect_val("vec_dout", 16'h0047);
    check(ack_dout_busy);
    rd_check(3'd0, "vec_pend_after", 16'h0000);
    wr_reg(3'd1, 2'b11, 16'h0000);
    wr_reg(3'd5, 2'b11, 16'h0000);
`endif

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
